uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_if.sv | 24 ++
 rtl/uart_tx_scheduler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter signals of the UART transmit scheduler.
// slave is the scheduler's view; master is the requester/transmitter side.
interface uart_tx_scheduler_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    output req0_ready, req1_ready, tx_start, tx_data, tx_done
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    input  req0_ready, req1_ready, tx_start, tx_data, tx_done
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin scheduler feeding a single UART transmitter.
// One byte is in flight at a time: grant, wait for the transmitter to go
// busy (bounded by TIMEOUT_CYCLES), then wait for it to finish.

// Per-requester ready: only the granted, valid requester sees ready while idle.
module uart_tx_sched_lane #(
  parameter logic LANE = 1'b0
) (
  input  logic idle,
  input  logic valid,
  input  logic grant,
  output logic ready
);
  assign ready = idle & valid & (grant == LANE);
endmodule

module uart_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_scheduler_if.slave  bus,
  output logic                last_grant,
  output logic                err_timeout,
  input  logic                err_clr,
  output logic [15:0]         sent_cnt
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_IDLE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0][7:0]   req_data;
  logic                      idle;
  logic                      grant;
  logic                      handshake;
  logic                      timeout_hit;
  logic                      done_c;
  logic [7:0]                tmo_cnt_q;
  logic [7:0]                tx_data_q;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_data  = {bus.req1_data, bus.req0_data};
  assign idle      = (state_q == IDLE);

  // Arbitration: a lone requester wins; on contention the one not served last.
  always_comb begin
    grant = req_valid[1];
    if (&req_valid) grant = ~last_grant;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    uart_tx_sched_lane #(.LANE(1'(i))) u_lane (
      .idle  (idle),
      .valid (req_valid[i]),
      .grant (grant),
      .ready (req_ready[i])
    );
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];
  assign handshake      = |req_ready;

  // The last waiting cycle is the TIMEOUT_CYCLES-th cycle of tx_start high.
  assign timeout_hit = (state_q == WAIT_BUSY) && !bus.tx_busy &&
                       (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and frame-completion pulse.
  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE:      if (handshake) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)      state_d = WAIT_IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      WAIT_IDLE: begin
        if (!bus.tx_busy) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // Capture the granted byte and requester; held until the next handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q  <= 8'h00;
      last_grant <= 1'b1;
    end else if (handshake) begin
      tx_data_q  <= req_data[grant];
      last_grant <= grant;
    end
  end

  // Cycles spent waiting for the transmitter to pick up the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  tmo_cnt_q <= 8'd0;
    else if (handshake || timeout_hit)           tmo_cnt_q <= 8'd0;
    else if (state_q == WAIT_BUSY && !bus.tx_busy) tmo_cnt_q <= tmo_cnt_q + 8'd1;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_timeout <= 1'b0;
    else if (timeout_hit) err_timeout <= 1'b1;
    else if (err_clr)     err_timeout <= 1'b0;
  end

  // Completed-frame counter, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sent_cnt <= 16'h0000;
    else if (done_c) sent_cnt <= sent_cnt + 16'h0001;
  end

  assign bus.tx_start = (state_q == WAIT_BUSY);
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_done  = done_c;
endmodule
